step_drive_ctrl: RTL and testbench
==================================

# step_drive_ctrl

Stepper-drive sequencer between the balance/auto-swing state machine and the motor driver. Converts the level commands `enable`/`direct` into a ramped STEP/DIR/EN pulse train. Soft-starts and soft-stops every move, inserts a dead time on every direction reversal, and hard-stops on the track limit switches (`jockey_r`/`jockey_l`). Keeps a signed step position count for the adjust phase.

## Interface
- `PERIOD_MAX`, default 'd50_000: start/stop STEP half-period, in sclk cycles; must be ≥ `PERIOD_MIN`.
- `PERIOD_MIN`, default 'd5_000: cruise STEP half-period, in cycles; must be ≥ 1.
- `RAMP_STEP`, default 'd500: half-period change applied per STEP rising edge.
- `DEAD`, default 'd1_000_000: hold cycles after a stop, before any new move.
- `sclk` input 1: system clock; all logic runs on its rising edge.
- `s_rst_n` input 1: reset, synchronous, active-low.
- `enable` input 1: move request, level.
- `direct` input 1: requested direction (1 = clockwise/right); sampled only while `enable`=1; may be z otherwise.
- `jockey_r` input 1: right limit switch, active-low.
- `jockey_l` input 1: left limit switch, active-low.
- `step_out` output 1: STEP pulse to the driver.
- `dir_out` output 1: DIR to the driver; changes only in IDLE.
- `en_out` output 1: driver enable.
- `busy` output 1: high in any state other than IDLE.
- `fault` output 1: limit-stop flag.
- `pos` output 16: signed step position; wraps modulo 2^16.

## Operation
- All outputs are registered. Reset values: `step_out`=0, `dir_out`=0, `en_out`=0, `busy`=0, `fault`=0, `pos`=0. Internal state on reset: state=IDLE, `half_per`=`PERIOD_MAX`, `cnt`=0.
- Widths: `cnt` and `half_per` are 27 bit. Ramp arithmetic saturates:
  - decrement: `half_per` = max(`half_per` − `RAMP_STEP`, `PERIOD_MIN`)
  - increment: `half_per` = min(`half_per` + `RAMP_STEP`, `PERIOD_MAX`)
- "Limit active": `dir_out`=1 and `jockey_r`=0, or `dir_out`=0 and `jockey_l`=0.
- States are one-hot: IDLE, RUN, DECEL, DEAD, HALT.
- **IDLE:** `en_out`=0, `step_out`=0.
  - Start condition: `enable`=1 and the limit in `direct` is not active.
  - On start: `dir_out`←`direct`, `half_per`←`PERIOD_MAX`, `cnt`←0, go to RUN.
  - If `enable`=1 but the requested-direction limit is active: stay in IDLE, no fault.
- **Toggle rule (RUN and DECEL):** `cnt` increments each cycle. When `cnt` = `half_per`−1, `step_out` toggles and `cnt`←0.
  - Rising toggle: `pos` += 1 if `dir_out`=1, else −= 1.
- **RUN:**
  - On each rising toggle: `half_per` decrements (saturating).
  - `enable`=0, or `direct` ≠ `dir_out`: go to DECEL.
  - Limit active: go to HALT.
- **DECEL:**
  - On each rising toggle: `half_per` increments (saturating).
  - Falling toggle with `half_per` = `PERIOD_MAX`: go to DEAD.
  - `enable`=1 and `direct` = `dir_out`: return to RUN, keeping the current `half_per` and `cnt`.
  - Limit active: go to HALT.
- **DEAD:** `step_out`=0, `en_out`=1. Counts `DEAD` cycles, then goes to IDLE; IDLE then re-evaluates `enable`/`direct`, which implements reversal.
- **HALT:** `step_out`=0, `en_out`=0, `fault`=1.
  - Leave to IDLE only when `enable`=0; `fault` clears on that transition.
- **Priority within one cycle:** limit > command change > toggle/ramp. If the limit and a toggle coincide, no toggle occurs and `pos` does not change.
- `en_out`=1 in RUN, DECEL and DEAD.

## Timing
- `enable` is sampled at edge N: state=RUN, `en_out`=1, `busy`=1 are visible after edge N+1.
- First `step_out` rise comes `PERIOD_MAX` cycles after RUN entry.
- Half-period sequence during acceleration: `PERIOD_MAX`, then each value twice (high phase and low phase), stepping down by `RAMP_STEP` at each rise until `PERIOD_MIN`.
- Limit response: the limit is sampled at edge N; `step_out`=0, `en_out`=0, `fault`=1 after edge N+1.
- A reversal always passes through DECEL → DEAD → IDLE → RUN; `dir_out` never changes while `en_out`=1 and stepping.
- Reset asserted mid-move: all outputs return to their reset values at the next sclk edge, regardless of state.

## Test plan
Parameters for all scenarios: `PERIOD_MAX`=8, `PERIOD_MIN`=2, `RAMP_STEP`=2, `DEAD`=4.
- **Reset mid-RUN:** hold `s_rst_n`=0 for 1 cycle → next edge: all outputs 0, state IDLE. Release reset with `enable`=0 → stays IDLE.
- **Accelerate:** `enable`=1, `direct`=1, limits high → `dir_out`=1, `en_out`=1 after 1 cycle. `step_out` phase lengths 8,6,6,4,4,2,2,2… `pos` = 1,2,3… at each rise.
- **Stop:** drop `enable` at cruise → half-periods grow 2→4→6→8. `step_out` ends low; `en_out` stays 1 for 4 more cycles, then 0; `busy`=0 and `pos` frozen.
- **Reversal:** at cruise, set `direct`=0 → decel, dead 4 cycles, IDLE one cycle, then RUN with `dir_out`=0. `pos` decrements from its held value.
- **Limit hit:** at cruise with `dir_out`=1, pull `jockey_r`=0 → next edge: `step_out`=0, `en_out`=0, `fault`=1. Fault holds while `enable`=1; `enable`=0 → IDLE, `fault`=0. Then `enable`=1, `direct`=1 with `jockey_r` still 0 → stays IDLE.
- **Re-enable during DECEL:** drop `enable` at `half_per`=2, restore after the first rise with `half_per`=4 → return to RUN, phase lengths 4,4,2,2… with no DEAD gap and no `dir_out` change.

Source files
------------

// File: rtl/step_drive_ctrl_if.sv
// Command and driver-side signal bundle for the stepper drive sequencer.
// The master side is the balance/auto-swing controller (commands and limit
// switches); the slave side is step_drive_ctrl itself.
interface step_drive_ctrl_if;
   logic        enable;
   logic        direct;
   logic        jockey_r;
   logic        jockey_l;
   logic        step_out;
   logic        dir_out;
   logic        en_out;
   logic        busy;
   logic        fault;
   logic [15:0] pos;

   modport master (
      output enable, direct, jockey_r, jockey_l,
      input  step_out, dir_out, en_out, busy, fault, pos
   );

   modport slave (
      input  enable, direct, jockey_r, jockey_l,
      output step_out, dir_out, en_out, busy, fault, pos
   );
endinterface

// File: rtl/step_drive_ctrl.sv
// Stepper-drive sequencer: turns level move commands into a ramped
// STEP/DIR/EN pulse train with soft start/stop, a dead time after every
// stop and a hard stop on the track limit switches. Keeps a signed step
// position count.
module step_drive_ctrl #(
   parameter int PERIOD_MAX = 50_000,
   parameter int PERIOD_MIN = 5_000,
   parameter int RAMP_STEP  = 500,
   parameter int DEAD       = 1_000_000
) (
   input logic              sclk,
   input logic              s_rst_n,
   step_drive_ctrl_if.slave bus
);

   localparam logic [26:0] P_MAX  = 27'(PERIOD_MAX);
   localparam logic [26:0] P_MIN  = 27'(PERIOD_MIN);
   localparam logic [26:0] P_RAMP = 27'(RAMP_STEP);
   localparam logic [26:0] P_DEAD = 27'(DEAD);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_RUN   = 5'b00010,
      S_DECEL = 5'b00100,
      S_DEAD  = 5'b01000,
      S_HALT  = 5'b10000
   } state_t;

   state_t      state_reg;
   logic [26:0] half_per_reg;
   logic [26:0] cnt_reg;
   logic        step_reg;
   logic        dir_reg;
   logic        en_reg;
   logic        busy_reg;
   logic        fault_reg;
   logic [15:0] pos_reg;

   logic        limit_cur;
   logic        limit_req;
   logic        hold_cmd;
   logic        toggle;
   logic [26:0] half_dec;
   logic [26:0] half_inc;
   logic [15:0] pos_next;

   // Limit in the current travel direction, and in the requested one.
   assign limit_cur = dir_reg     ? ~bus.jockey_r : ~bus.jockey_l;
   assign limit_req = bus.direct  ? ~bus.jockey_r : ~bus.jockey_l;
   // Command still asks to keep moving the way we already move.
   // enable is tested first so a floating direct is never looked at.
   assign hold_cmd  = bus.enable && (bus.direct == dir_reg);
   assign toggle    = (cnt_reg == half_per_reg - 27'd1);

   // Saturating ramp arithmetic; written to avoid wrap on the subtraction.
   assign half_dec  = (half_per_reg > P_MIN + P_RAMP) ? half_per_reg - P_RAMP : P_MIN;
   assign half_inc  = ((P_MAX - half_per_reg) > P_RAMP) ? half_per_reg + P_RAMP : P_MAX;
   assign pos_next  = dir_reg ? pos_reg + 16'd1 : pos_reg - 16'd1;

   assign bus.step_out = step_reg;
   assign bus.dir_out  = dir_reg;
   assign bus.en_out   = en_reg;
   assign bus.busy     = busy_reg;
   assign bus.fault    = fault_reg;
   assign bus.pos      = pos_reg;

   // Sequencer FSM with all driver outputs registered.
   // A command change in RUN/DECEL only switches state that cycle: the
   // counter holds its value, so the phase in progress is one cycle longer
   // and half_per/cnt carry over unchanged into the new state.
   always_ff @(posedge sclk) begin
      if (!s_rst_n) begin
         state_reg    <= S_IDLE;
         half_per_reg <= P_MAX;
         cnt_reg      <= '0;
         step_reg     <= 1'b0;
         dir_reg      <= 1'b0;
         en_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         fault_reg    <= 1'b0;
         pos_reg      <= '0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               step_reg <= 1'b0;
               en_reg   <= 1'b0;
               if (bus.enable && !limit_req) begin
                  dir_reg      <= bus.direct;
                  half_per_reg <= P_MAX;
                  cnt_reg      <= '0;
                  en_reg       <= 1'b1;
                  busy_reg     <= 1'b1;
                  state_reg    <= S_RUN;
               end
            end

            S_RUN: begin
               if (limit_cur) begin
                  step_reg  <= 1'b0;
                  en_reg    <= 1'b0;
                  fault_reg <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= S_HALT;
               end else if (!hold_cmd) begin
                  state_reg <= S_DECEL;
               end else if (toggle) begin
                  step_reg <= ~step_reg;
                  cnt_reg  <= '0;
                  if (!step_reg) begin
                     pos_reg      <= pos_next;
                     half_per_reg <= half_dec;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 27'd1;
               end
            end

            S_DECEL: begin
               if (limit_cur) begin
                  step_reg  <= 1'b0;
                  en_reg    <= 1'b0;
                  fault_reg <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= S_HALT;
               end else if (hold_cmd) begin
                  state_reg <= S_RUN;
               end else if (toggle) begin
                  step_reg <= ~step_reg;
                  cnt_reg  <= '0;
                  if (!step_reg) begin
                     pos_reg      <= pos_next;
                     half_per_reg <= half_inc;
                  end else if (half_per_reg == P_MAX) begin
                     // Back at start/stop speed with STEP low: move is over.
                     state_reg <= S_DEAD;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 27'd1;
               end
            end

            S_DEAD: begin
               step_reg <= 1'b0;
               en_reg   <= 1'b1;
               if (cnt_reg == P_DEAD - 27'd1) begin
                  cnt_reg   <= '0;
                  en_reg    <= 1'b0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 27'd1;
               end
            end

            S_HALT: begin
               step_reg  <= 1'b0;
               en_reg    <= 1'b0;
               fault_reg <= 1'b1;
               if (!bus.enable) begin
                  fault_reg <= 1'b0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end

            default: begin
               step_reg  <= 1'b0;
               en_reg    <= 1'b0;
               busy_reg  <= 1'b0;
               fault_reg <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_drive_ctrl.sv
// Directed bench for step_drive_ctrl with PERIOD_MAX=8, PERIOD_MIN=2,
// RAMP_STEP=2, DEAD=4: a cycle-counted vector table for reset, ramp-up and
// soft stop, then hand-written sequences for reversal, limit stop,
// re-enable during deceleration and reset mid-move.
module tb_step_drive_ctrl;

   logic sclk    = 1'b0;
   logic s_rst_n = 1'b0;

   always #5 sclk = ~sclk;

   step_drive_ctrl_if bus ();

   step_drive_ctrl #(
      .PERIOD_MAX (8),
      .PERIOD_MIN (2),
      .RAMP_STEP  (2),
      .DEAD       (4)
   ) dut (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .bus     (bus)
   );

   typedef struct {
      bit rst_n;
      bit en;
      bit dir;
      bit jr;
      bit jl;
      int n;
      bit e_step;
      bit e_dir;
      bit e_en;
      bit e_busy;
      bit e_fault;
      int e_pos;
   } vec_t;

   vec_t tbl [20];

   int n_cmp      = 0;
   int n_bad      = 0;
   int dir_glitch = 0;
   int busy_low   = 0;
   bit prev_en    = 1'b0;
   bit prev_dir   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock; samples are taken 1 time unit after the rising edge.
   task automatic tick();
      @(posedge sclk);
      #1;
      if (prev_en && bus.en_out && (bus.dir_out != prev_dir)) dir_glitch++;
      if (!bus.busy) busy_low++;
      prev_en  = bus.en_out;
      prev_dir = bus.dir_out;
   endtask

   // Waits for a STEP edge of the given polarity; reports the cycle count.
   task automatic wait_edge(input bit rising, input string name, output int cycles);
      bit found;
      bit prev;
      found  = 1'b0;
      cycles = 0;
      while (!found && cycles < 200) begin
         prev = bus.step_out;
         tick();
         cycles++;
         if (bus.step_out == rising && prev != rising) found = 1'b1;
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no STEP edge within %0d cycles", name, cycles);
      end
   endtask

   // Waits until busy equals the given level; reports the cycle count.
   task automatic wait_busy(input bit level, input string name, output int cycles);
      cycles = 0;
      while (bus.busy != level && cycles < 200) begin
         tick();
         cycles++;
      end
      if (bus.busy != level) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: busy stuck at %0d", name, bus.busy);
      end
   endtask

   task automatic check_outs(input string name, input bit st, input bit dr, input bit en,
                             input bit bs, input bit ft, input int ps);
      check({name, ".step"},  int'(bus.step_out), int'(st));
      check({name, ".dir"},   int'(bus.dir_out),  int'(dr));
      check({name, ".en"},    int'(bus.en_out),   int'(en));
      check({name, ".busy"},  int'(bus.busy),     int'(bs));
      check({name, ".fault"}, int'(bus.fault),    int'(ft));
      check({name, ".pos"},   int'(bus.pos),      ps);
   endtask

   initial begin
      int cyc;

      bus.enable   = 1'b0;
      bus.direct   = 1'b0;
      bus.jockey_r = 1'b1;
      bus.jockey_l = 1'b1;

      //          rst en dir jr jl  n  | step dir en busy fault pos
      tbl[0]  = '{0, 0, 0, 1, 1,  2,    0,   0,  0, 0,   0,    0};
      tbl[1]  = '{1, 0, 0, 1, 1,  3,    0,   0,  0, 0,   0,    0};
      tbl[2]  = '{1, 1, 1, 1, 1,  1,    0,   1,  1, 1,   0,    0};
      tbl[3]  = '{1, 1, 1, 1, 1,  7,    0,   1,  1, 1,   0,    0};
      tbl[4]  = '{1, 1, 1, 1, 1,  1,    1,   1,  1, 1,   0,    1};
      tbl[5]  = '{1, 1, 1, 1, 1,  5,    1,   1,  1, 1,   0,    1};
      tbl[6]  = '{1, 1, 1, 1, 1,  1,    0,   1,  1, 1,   0,    1};
      tbl[7]  = '{1, 1, 1, 1, 1,  6,    1,   1,  1, 1,   0,    2};
      tbl[8]  = '{1, 1, 1, 1, 1,  8,    1,   1,  1, 1,   0,    3};
      tbl[9]  = '{1, 1, 1, 1, 1,  4,    1,   1,  1, 1,   0,    4};
      tbl[10] = '{1, 0, 1, 1, 1,  1,    1,   1,  1, 1,   0,    4};
      tbl[11] = '{1, 0, 1, 1, 1,  2,    0,   1,  1, 1,   0,    4};
      tbl[12] = '{1, 0, 1, 1, 1,  2,    1,   1,  1, 1,   0,    5};
      tbl[13] = '{1, 0, 1, 1, 1,  8,    1,   1,  1, 1,   0,    6};
      tbl[14] = '{1, 0, 1, 1, 1, 12,    1,   1,  1, 1,   0,    7};
      tbl[15] = '{1, 0, 1, 1, 1,  7,    1,   1,  1, 1,   0,    7};
      tbl[16] = '{1, 0, 1, 1, 1,  1,    0,   1,  1, 1,   0,    7};
      tbl[17] = '{1, 0, 1, 1, 1,  3,    0,   1,  1, 1,   0,    7};
      tbl[18] = '{1, 0, 1, 1, 1,  1,    0,   1,  0, 0,   0,    7};
      tbl[19] = '{1, 0, 1, 1, 1,  3,    0,   1,  0, 0,   0,    7};

      // Reset, acceleration 8,6,6,4,4,2,2 and soft stop 2,4,6,8 + dead time.
      for (int i = 0; i < 20; i++) begin
         s_rst_n      = tbl[i].rst_n;
         bus.enable   = tbl[i].en;
         bus.direct   = tbl[i].dir;
         bus.jockey_r = tbl[i].jr;
         bus.jockey_l = tbl[i].jl;
         for (int k = 0; k < tbl[i].n; k++) tick();
         $display("row %0d: step=%0d dir=%0d en=%0d busy=%0d fault=%0d pos=%0d",
                  i, bus.step_out, bus.dir_out, bus.en_out, bus.busy, bus.fault, bus.pos);
         check_outs($sformatf("row%0d", i), tbl[i].e_step, tbl[i].e_dir, tbl[i].e_en,
                    tbl[i].e_busy, tbl[i].e_fault, tbl[i].e_pos);
      end

      // Reversal: cruise right, request left.
      bus.enable = 1'b1;
      bus.direct = 1'b1;
      for (int r = 0; r < 4; r++) wait_edge(1'b1, "rev.accel", cyc);
      check("rev.cruise_pos", int'(bus.pos), 11);
      bus.direct = 1'b0;
      for (int r = 0; r < 3; r++) wait_edge(1'b1, "rev.decel", cyc);
      check("rev.decel_pos", int'(bus.pos), 14);
      check("rev.decel_dir", int'(bus.dir_out), 1);
      wait_edge(1'b0, "rev.last_fall", cyc);
      check("rev.dead_en", int'(bus.en_out), 1);
      wait_busy(1'b0, "rev.dead", cyc);
      check("rev.dead_len", cyc, 4);
      wait_busy(1'b1, "rev.idle", cyc);
      check("rev.idle_len", cyc, 1);
      check("rev.new_dir", int'(bus.dir_out), 0);
      check("rev.new_en", int'(bus.en_out), 1);
      wait_edge(1'b1, "rev.first_rise", cyc);
      check("rev.first_rise_len", cyc, 8);
      check("rev.pos_dec", int'(bus.pos), 13);
      $display("reversal done: pos=%0d dir=%0d", bus.pos, bus.dir_out);

      // Stop during the left move, then move right into the limit switch.
      bus.enable = 1'b0;
      wait_busy(1'b0, "lim.stop", cyc);
      check("lim.stop_pos", int'(bus.pos), 12);
      bus.enable = 1'b1;
      bus.direct = 1'b1;
      for (int r = 0; r < 4; r++) wait_edge(1'b1, "lim.accel", cyc);
      check("lim.cruise_pos", int'(bus.pos), 16);
      for (int k = 0; k < 3; k++) tick();
      // Next edge would be a rising toggle; the limit must pre-empt it.
      bus.jockey_r = 1'b0;
      tick();
      check_outs("lim.hit", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16);
      for (int k = 0; k < 3; k++) tick();
      check("lim.hold_fault", int'(bus.fault), 1);
      check("lim.hold_busy", int'(bus.busy), 1);
      bus.enable = 1'b0;
      tick();
      check("lim.clear_fault", int'(bus.fault), 0);
      check("lim.clear_busy", int'(bus.busy), 0);
      bus.enable = 1'b1;
      bus.direct = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      check_outs("lim.blocked", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16);
      $display("limit done: fault=%0d busy=%0d pos=%0d", bus.fault, bus.busy, bus.pos);
      bus.jockey_r = 1'b1;
      bus.enable   = 1'b0;
      tick();

      // Re-enable during deceleration: back to RUN with no dead gap.
      bus.enable = 1'b1;
      bus.direct = 1'b1;
      for (int r = 0; r < 4; r++) wait_edge(1'b1, "reen.accel", cyc);
      check("reen.cruise_pos", int'(bus.pos), 20);
      busy_low   = 0;
      bus.enable = 1'b0;
      wait_edge(1'b1, "reen.decel_rise", cyc);
      check("reen.decel_pos", int'(bus.pos), 21);
      bus.enable = 1'b1;
      wait_edge(1'b0, "reen.high4", cyc);
      check("reen.high4_len", cyc, 5);
      wait_edge(1'b1, "reen.low4", cyc);
      check("reen.low4_len", cyc, 4);
      check("reen.pos", int'(bus.pos), 22);
      wait_edge(1'b0, "reen.high2", cyc);
      check("reen.high2_len", cyc, 2);
      wait_edge(1'b1, "reen.low2", cyc);
      check("reen.low2_len", cyc, 2);
      check("reen.pos2", int'(bus.pos), 23);
      check("reen.no_dead_gap", busy_low, 0);
      check("reen.dir", int'(bus.dir_out), 1);
      $display("re-enable done: pos=%0d busy=%0d", bus.pos, bus.busy);

      // Reset asserted mid-RUN.
      s_rst_n = 1'b0;
      tick();
      check_outs("rst.mid_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      s_rst_n    = 1'b1;
      bus.enable = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check_outs("rst.released", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      $display("reset done: busy=%0d pos=%0d", bus.busy, bus.pos);

      check("dir_stable_while_enabled", dir_glitch, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
